// File: rtl/byte_serial_adder.sv
// Multi-byte adder/subtractor that time-shares one 8-bit carry-lookahead adder,
// processing one byte per cycle LSB first behind valid/ready handshakes.

module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Each carry is a flat sum-of-products of generates and propagates, not a ripple chain.
  always_comb begin
    logic term;
    logic prod;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      term = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = term | (prod & ci);
    end
    s  = p ^ c[7:0];
    co = c[8];
  end

endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                overflow
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        nextState;
  logic [IW-1:0] idx;
  logic [W-1:0]  aReg;
  logic [W-1:0]  bEff;
  logic          carry;
  logic [W-1:0]  aShift;
  logic [W-1:0]  bShift;
  logic [7:0]    claS;
  logic          claCo;
  logic          accept;

  assign accept = (state == IDLE) && in_valid;
  assign aShift = aReg >> (8 * idx);
  assign bShift = bEff >> (8 * idx);

  cla_8bit u_cla (
    .a  (aShift[7:0]),
    .b  (bShift[7:0]),
    .ci (carry),
    .s  (claS),
    .co (claCo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid)     nextState = RUN;
      RUN:     if (idx == LAST)  nextState = DONE;
      DONE:    if (out_ready)    nextState = IDLE;
      default:                   nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Subtraction becomes A + ~B + ~cin, so cout reads as "no borrow".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      aReg     <= '0;
      bEff     <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      aReg  <= a;
      bEff  <= op_sub ? ~b : b;
      carry <= cin ^ op_sub;
    end else if (state == RUN) begin
      sum[8*idx +: 8] <= claS;
      carry           <= claCo;
      if (idx == LAST) begin
        cout     <= claCo;
        overflow <= (aReg[W-1] == bEff[W-1]) && (claS[7] != aReg[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Randomized self-checking bench for byte_serial_adder (NBYTES=4) against an
// integer-arithmetic reference model.

module tb_byte_serial_adder;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          op_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;

  int checks = 0;
  int passes = 0;

  byte_serial_adder #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Reference: plain integer arithmetic on the mathematical values.
  function automatic void refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                   input logic rc, input logic rs,
                                   output logic [W-1:0] es, output logic ec, output logic eo);
    longint unsigned ua = longint'(ra);
    longint unsigned ub = longint'(rb);
    longint unsigned uc = longint'(rc);
    longint sa = longint'($signed(ra));
    longint sb = longint'($signed(rb));
    longint sres;
    longint unsigned total;
    if (!rs) begin
      total = ua + ub + uc;
      es    = total[W-1:0];
      ec    = (total >= 64'h1_0000_0000);
      sres  = sa + sb + longint'(rc);
    end else begin
      total = ua - ub - uc;
      es    = total[W-1:0];
      ec    = (ua >= ub + uc);
      sres  = sa - sb - longint'(rc);
    end
    eo = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
  endfunction

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tc, input logic ts, input int holdCycles);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    logic [W-1:0] heldSum;
    int           lat;
    refModel(ta, tb, tc, ts, es, ec, eo);
    @(negedge clk);
    checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = ta; b = tb; cin = tc; op_sub = ts;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); op_sub = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat < NBYTES) checkOutput("in_ready_run", 64'(in_ready), 64'd0);
    end while (!out_valid && lat < 20);
    if (!out_valid) begin
      checkOutput("timeout_out_valid", 64'(out_valid), 64'd1);
      return;
    end
    checkOutput("latency", 64'(lat), 64'(NBYTES));
    checkOutput("sum", 64'(sum), 64'(es));
    checkOutput("cout", 64'(cout), 64'(ec));
    checkOutput("overflow", 64'(overflow), 64'(eo));
    heldSum = sum;
    // Backpressure: new operands offered while DONE must be ignored.
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = ~in_valid; a = $urandom; b = $urandom;
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      checkOutput("hold_sum", 64'(sum), 64'(heldSum));
      checkOutput("hold_flags", 64'({cout, overflow}), 64'({ec, eo}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("out_valid_drop", 64'(out_valid), 64'd0);
    checkOutput("in_ready_back", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    checkOutput("rst_flags", 64'({out_valid, cout, overflow}), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0);
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 3);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1);

    // Reset mid-RUN at idx=2 with a live carry and partial sum bytes.
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b0; op_sub = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrun_rst_sum", 64'(sum), 64'd0);
    checkOutput("midrun_rst_flags", 64'({out_valid, cout, overflow}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 8 == 0) ra = {1'b0, {(W-1){1'b1}}};
      if (n % 8 == 1) rb = '1;
      applyStimulus(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
